nor_truth_sequencer: RTL
========================

// Module: nor_truth_sequencer
// PURPOSE
//  Self-checking stimulus controller for one N-input NOR gate instance (e.g. nor1).
//  On start it walks gate_in through every vector 0..2^N_IN-1 and waits SETTLE cycles per vector.
//  It then samples gate_out, compares it with ~|vec and reports done/pass plus an error count.
//  It sits beside the gate under test in FPGA/bench builds and replaces hand-written stimulus loops.
// PARAMETERS
//  N_IN    2  number of gate inputs (1..8)
//  SETTLE  2  cycles gate_in is held before sampling (>=1; 0 is an elaboration error)
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          asynchronous, active-high reset
//  start           in   1          begin a sweep; accepted only in IDLE
//  abort           in   1          cancel a sweep in progress
//  gate_in         out  N_IN       registered drive to the gate inputs ({a,b} order, MSB = a)
//  gate_out        in   1          gate output under test
//  busy            out  1          high in SETTLE or SAMPLE
//  done            out  1          one-cycle pulse when a sweep completes
//  pass            out  1          1 = last completed sweep had err_count==0; held until next start
//  err_count       out  N_IN+1     mismatches in current/last sweep
//  first_fail_vec  out  N_IN       (FAIL_CAPTURE_EN only) vector of first mismatch
//  first_fail_vld  out  1          (FAIL_CAPTURE_EN only) first_fail_vec is valid
// BEHAVIOUR
//  - Reset: state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_count=0, settle cnt=0,
//    first_fail_vld=0, first_fail_vec=0.
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE: if start && !abort, then at that edge gate_in<=0, cnt<=0, err_count<=0, pass<=0,
//    first_fail_vld<=0, and the state goes to SETTLE.
//  - SETTLE: cnt increments each edge. When cnt==SETTLE-1 the state goes to SAMPLE.
//    Exactly SETTLE cycles are spent in SETTLE.
//  - SAMPLE (1 cycle): mismatch = (gate_out != ~|gate_in); if mismatch, err_count<=err_count+1.
//    err_count cannot overflow: its width holds 2^N_IN.
//    If gate_in == 2^N_IN-1 the state goes to DONE. Otherwise gate_in<=gate_in+1, cnt<=0, state to SETTLE.
//  - DONE (1 cycle): done=1 (decoded from state). pass<=(err_count==0) at the DONE->IDLE edge. Then IDLE.
//  - The error count includes the final-vector mismatch: pass is evaluated after the SAMPLE update.
//  - Per-vector cost: SETTLE+1 cycles. Start accepted at edge k => DONE state begins at edge k+2^N_IN*(SETTLE+1).
//  - gate_in stays stable throughout SETTLE and SAMPLE of a vector. It changes only on SAMPLE->SETTLE.
//  - abort in SETTLE/SAMPLE: next state IDLE, no done pulse, pass=0, gate_in<=0, err_count retained.
//  - abort in IDLE/DONE: no effect. A DONE cycle always completes.
//  - start while busy or in DONE is ignored, not queued. Same-cycle start+abort in IDLE: abort wins, stay IDLE.
//  - rst mid-sweep: immediate return to reset values, no done pulse.
//  - gate_out is used only in SAMPLE. It is a synchronous-design input; no synchroniser here.
// CONFIGURATION
//  FAIL_CAPTURE_EN defined: in SAMPLE, on a mismatch while first_fail_vld==0,
//    first_fail_vec<=gate_in and first_fail_vld<=1. Both are cleared on accepted start and on rst.
//  Not defined: first_fail_vec/first_fail_vld ports and their logic are absent; all else identical.
// STRUCTURE
//  Package gate_seq_pkg: state_t enum {IDLE,SETTLE,SAMPLE,DONE}, localparam defaults
//    N_IN_DEF=2 and SETTLE_DEF=2, and function nor_ref(vec) returning ~|vec.
//  Sub-module settle_timer (clear, enable, SETTLE param -> expire flag) owns cnt.
//    The FSM, vector register and checker stay in nor_truth_sequencer.
// TESTING (bench: nor_truth_sequencer_tb with nor1 as the gate, N_IN=2, SETTLE=2, unless noted)
//  1 Correct gate, start pulse at edge k -> gate_in steps 00,01,10,11, each held 3 cycles;
//    done high exactly in cycle after edge k+12; pass=1, err_count=0.
//  2 Gate replaced by OR model -> err_count=4, pass=0; with FAIL_CAPTURE_EN, first_fail_vec=00, vld=1.
//  3 Stuck-at-0 output -> mismatch only at vector 00; err_count=1, pass=0;
//    with FAIL_CAPTURE_EN, first_fail_vec=00.
//  4 abort asserted while gate_in=10 in SETTLE -> IDLE next cycle, gate_in=0,
//    no done pulse, pass=0, err_count=0.
//  5 start re-pulsed while busy and start+abort together in IDLE -> both ignored; a sweep launched later runs normally.
//  6 rst asserted mid-SAMPLE (async, between edges) -> all outputs at reset values immediately;
//    next start yields a full 12-cycle sweep; repeat with N_IN=3, SETTLE=1: done at k+16.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared state encoding, default sizing and NOR reference for the truth-table sequencer
package gate_seq_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam int N_IN_DEF = 2;
  localparam int SETTLE_DEF = 2;
  function automatic logic nor_ref(input logic [7:0] vec);
    return ~|vec;
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts cycles spent holding a vector; expire flags the last settle cycle
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  if (SETTLE < 1) begin : g_bad_settle
    $error("settle_timer: SETTLE must be at least 1");
  end
  assign expire = cnt_q == LAST;
  always_comb cnt_d = clear ? '0 : (enable && !expire) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/nor_truth_sequencer.sv
// nor_truth_sequencer: sweeps every input vector of a NOR gate and counts output mismatches.
// FAIL_CAPTURE_EN adds first_fail_vec/first_fail_vld recording the first failing vector.
module nor_truth_sequencer #(
  parameter int N_IN = gate_seq_pkg::N_IN_DEF,
  parameter int SETTLE = gate_seq_pkg::SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count
`ifdef FAIL_CAPTURE_EN
  ,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_vld
`endif
);
  import gate_seq_pkg::*;
  state_t state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0] err_q, err_d;
  logic pass_q, pass_d, expire, mismatch, in_settle, halt, accept;
  if (N_IN < 1 || N_IN > 8) begin : g_bad_n
    $error("nor_truth_sequencer: N_IN must be 1..8");
  end
  assign in_settle = state_q == gate_seq_pkg::SETTLE;
  assign halt = abort && (in_settle || state_q == SAMPLE);
  assign accept = state_q == IDLE && start && !abort;
  assign mismatch = gate_out != nor_ref(8'(vec_q));
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(!in_settle),
    .enable(in_settle),
    .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    err_d = err_q;
    pass_d = pass_q;
    if (halt) begin
      state_d = IDLE;
      vec_d = '0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_d = gate_seq_pkg::SETTLE;
          vec_d = '0;
          err_d = '0;
          pass_d = 1'b0;
        end
        gate_seq_pkg::SETTLE: state_d = expire ? SAMPLE : state_q;
        SAMPLE: begin
          err_d = err_q + (N_IN+1)'(mismatch);
          state_d = &vec_q ? DONE : gate_seq_pkg::SETTLE;
          vec_d = &vec_q ? vec_q : vec_q + N_IN'(1);
        end
        default: begin
          state_d = IDLE;
          pass_d = err_q == '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      err_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      err_q <= err_d;
      pass_q <= pass_d;
    end
`ifdef FAIL_CAPTURE_EN
  logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
  logic first_fail_vld_q, first_fail_vld_d;
  always_comb begin
    first_fail_vec_d = accept ? '0 : first_fail_vec_q;
    first_fail_vld_d = accept ? 1'b0 : first_fail_vld_q;
    if (state_q == SAMPLE && !abort && mismatch && !first_fail_vld_q) begin
      first_fail_vec_d = vec_q;
      first_fail_vld_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      first_fail_vec_q <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      first_fail_vec_q <= first_fail_vec_d;
      first_fail_vld_q <= first_fail_vld_d;
    end
  assign first_fail_vec = first_fail_vec_q;
  assign first_fail_vld = first_fail_vld_q;
`endif
  assign gate_in = vec_q;
  assign busy = in_settle || state_q == SAMPLE;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
endmodule
